// File: rtl/teclado_scan.sv
// teclado_scan: 4x4 matrix keypad scanner with debounce, one key event per press
//   optional auto-repeat while a key is held: define TECLADO_REPEAT_EN
//   clk           : system clock
//   rst           : synchronous active-high reset
//   row_n[3:0]    : keypad rows, active-low, asynchronous to clk
//   col_n[3:0]    : column drive, active-low, exactly one bit low
//   key_valid     : one-cycle pulse marking a key event
//   key_code[3:0] : code of the last accepted key
module teclado_scan #(
  parameter int SCAN_CYCLES     = 1,
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int REPEAT_DELAY    = 1000,
  parameter int REPEAT_PERIOD   = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic       key_valid,
  output logic [3:0] key_code
);
  localparam int M1 = SCAN_CYCLES > DEBOUNCE_CYCLES ? SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int M2 = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW = $clog2(M1 > M2 ? M1 : M2) + 1;
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0] SCAN = 2'd0, DEBOUNCE = 2'd1, EMIT = 2'd2, RELEASE = 2'd3;
  localparam logic [63:0] KMAP = 64'hDF0E_C987_B654_A321;
  logic [3:0] s1, rs, col_d1, col_d2, pat;
  logic [1:0] state, row_idx, col_idx, rs_idx, tag_idx;
  logic [CW-1:0] scnt, dcnt, dcnt_inc;
  logic one_low, stale;
  // col_d2 is the column that was driven when the current rs sample was taken
  always_comb begin
    one_low = $countones(~rs) == 1;
    rs_idx = !rs[0] ? 2'd0 : !rs[1] ? 2'd1 : !rs[2] ? 2'd2 : 2'd3;
    tag_idx = !col_d2[0] ? 2'd0 : !col_d2[1] ? 2'd1 : !col_d2[2] ? 2'd2 : 2'd3;
    pat = ~(4'b0001 << row_idx);
    stale = col_d2 != col_n;
    dcnt_inc = &dcnt ? dcnt : dcnt + ONE;
  end
  // After freezing col_n on the detected column, the samples still in the
  // synchronizer belong to other columns; they advance time but cannot abort.
  always_ff @(posedge clk)
    if (rst) begin
      s1 <= 4'hF;
      rs <= 4'hF;
      col_d1 <= 4'b1110;
      col_d2 <= 4'b1110;
      col_n <= 4'b1110;
      state <= SCAN;
      row_idx <= '0;
      col_idx <= '0;
      scnt <= '0;
      dcnt <= '0;
      key_code <= 4'h0;
    end else begin
      s1 <= row_n;
      rs <= s1;
      col_d1 <= col_n;
      col_d2 <= col_d1;
      case (state)
        SCAN:
          if (one_low) begin
            row_idx <= rs_idx;
            col_idx <= tag_idx;
            col_n <= ~(4'b0001 << tag_idx);
            scnt <= '0;
            dcnt <= '0;
            state <= DEBOUNCE;
          end else if (scnt >= SCAN_LAST) begin
            scnt <= '0;
            col_n <= {col_n[2:0], col_n[3]};
          end else
            scnt <= scnt + ONE;
        DEBOUNCE:
          if (stale)
            dcnt <= dcnt_inc;
          else if (rs != pat)
            state <= SCAN;
          else if (dcnt >= DEB_LAST) begin
            state <= EMIT;
            key_code <= KMAP[{row_idx, col_idx, 2'b00} +: 4];
          end else
            dcnt <= dcnt_inc;
        EMIT: begin
          state <= RELEASE;
          dcnt <= '0;
        end
        RELEASE:
          if (rs != 4'hF)
            dcnt <= '0;
          else if (dcnt >= DEB_LAST) begin
            dcnt <= '0;
            state <= SCAN;
          end else
            dcnt <= dcnt_inc;
        default: state <= SCAN;
      endcase
    end
`ifdef TECLADO_REPEAT_EN
  localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);
  logic [CW-1:0] rcnt;
  logic rfirst, rep_hit, held;
  always_comb begin
    held = state == RELEASE && rs == pat;
    rep_hit = held && rcnt == (rfirst ? RD_LAST : RP_LAST);
    key_valid = state == EMIT || rep_hit;
  end
  always_ff @(posedge clk)
    if (rst || !held) begin
      rcnt <= '0;
      rfirst <= 1'b1;
    end else if (rep_hit) begin
      rcnt <= '0;
      rfirst <= 1'b0;
    end else
      rcnt <= &rcnt ? rcnt : rcnt + ONE;
`else
  always_comb key_valid = state == EMIT;
`endif
endmodule

// File: tb/tb_teclado_scan.sv
// tb_teclado_scan: directed bench for teclado_scan with a behavioural keypad matrix
module tb_teclado_scan;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] row_n, col_n, key_code, exp_col;
  logic key_valid;
  logic [15:0] keys = '0;
  logic [3:0] last_code = '0;
  logic prev_kv = 1'b0;
  int n_tests = 0, n_fail = 0, cyc = 0, nval = 0, last_cyc = 0, v0 = 0, p0 = 0;

  teclado_scan dut (
    .clk(clk), .rst(rst), .row_n(row_n),
    .col_n(col_n), .key_valid(key_valid), .key_code(key_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb
    for (int r = 0; r < 4; r++) row_n[r] = ~|(keys[r*4 +: 4] & ~col_n);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    keys = '0;
    tick(3);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (key_valid) begin
      check("no_back_to_back", {31'd0, prev_kv}, 32'd0);
      nval++;
      last_code = key_code;
      last_cyc = cyc;
    end
    prev_kv = key_valid;
  end

  initial begin
    tick(3);
    check("rst_col", {28'd0, col_n}, 32'hE);
    check("rst_valid", {31'd0, key_valid}, 32'd0);
    check("rst_code", {28'd0, key_code}, 32'd0);
    rst = 1'b0;
    exp_col = 4'b1110;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      exp_col = {exp_col[2:0], exp_col[3]};
      check("idle_scan_col", {28'd0, col_n}, {28'd0, exp_col});
    end
    check("idle_no_valid", nval, 0);

    do_reset();
    v0 = nval;
    p0 = cyc;
    keys[5] = 1'b1;
    tick(40);
    keys[5] = 1'b0;
    tick(30);
    check("k5_count", nval - v0, 1);
    check("k5_code", {28'd0, last_code}, 32'h5);
    check("k5_latency_le27", {31'd0, (last_cyc - p0) <= 27}, 32'd1);
    check("k5_code_holds", {28'd0, key_code}, 32'h5);

    do_reset();
    v0 = nval;
    p0 = cyc;
    for (int i = 0; i < 5; i++) begin
      keys[14] = (i % 2 == 0);
      tick(3);
    end
    tick(30);
    keys = '0;
    tick(30);
    check("hash_count", nval - v0, 1);
    check("hash_code", {28'd0, last_code}, 32'hF);
    check("hash_latency_window", {31'd0, (last_cyc - p0 - 12) >= 20 && (last_cyc - p0 - 12) <= 27}, 32'd1);

    do_reset();
    v0 = nval;
    keys[0] = 1'b1;
    keys[4] = 1'b1;
    exp_col = 4'b1110;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      exp_col = {exp_col[2:0], exp_col[3]};
      check("dual_scan_col", {28'd0, col_n}, {28'd0, exp_col});
    end
    tick(20);
    keys = '0;
    tick(10);
    check("dual_no_valid", nval - v0, 0);

    do_reset();
    v0 = nval;
    keys[12] = 1'b1;
    tick(12);
    rst = 1'b1;
    keys = '0;
    tick(1);
    rst = 1'b0;
    tick(40);
    check("star_abort_no_valid", nval - v0, 0);
    keys[12] = 1'b1;
    tick(40);
    keys = '0;
    tick(30);
    check("star_repress_count", nval - v0, 1);
    check("star_repress_code", {28'd0, last_code}, 32'hE);

    do_reset();
    v0 = nval;
    keys[5] = 1'b1;
    tick(30);
    keys[9] = 1'b1;
    tick(30);
    keys[5] = 1'b0;
    tick(30);
    check("second_key_held_count", nval - v0, 1);
    keys = '0;
    tick(40);
    check("second_key_released_count", nval - v0, 1);
    check("second_key_code", {28'd0, key_code}, 32'h5);

    do_reset();
    v0 = nval;
    keys[13] = 1'b1;
    tick(1600);
    keys = '0;
    tick(30);
`ifdef TECLADO_REPEAT_EN
    check("zero_long_count", nval - v0, 4);
`else
    check("zero_long_count", nval - v0, 1);
`endif
    check("zero_long_code", {28'd0, last_code}, 32'h0);
    check("zero_code_holds", {28'd0, key_code}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
